// File: rtl/sram_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the arbiter and the unified single-port sram.
// The arbiter uses the slave view; the requester/sram side uses the master view.
interface sram_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              ls_req;
  logic [7:0]        ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_err;

  logic              mem_en;
  logic [7:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port sram between instruction fetch (IF) and load/store (LS).
// Out-of-window or unaligned accesses are answered locally with an error flag and never reach the sram.
module sram_arbiter #(
  parameter int              ADDR_W    = 64,
  parameter int              DATA_W    = 64,
  parameter logic [ADDR_W-1:0] MEM_BASE  = 64'h0000_0000_8000_0000,
  parameter logic [ADDR_W-1:0] MEM_BYTES = 64'h0000_0000_0800_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_arbiter_if.slave  bus
);
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} own_e;

  own_e              r_rr_last;
  logic              r_rsp_vld;
  own_e              r_rsp_own;
  logic              r_rsp_err;
  logic              r_rsp_wr;

  logic              w_if_gnt;
  logic              w_ls_gnt;
  logic              w_any_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic              w_ok;
  logic              w_en;
  logic [DATA_W-1:0] w_rsp_data;

  // Grants are held low during reset so every output is quiet while rst_n is asserted.
  always_comb begin
    w_if_gnt  = rst_n & bus.if_req & (~bus.ls_req | (r_rr_last == OWN_LS));
    w_ls_gnt  = rst_n & bus.ls_req & (~bus.if_req | (r_rr_last == OWN_IF));
    w_any_gnt = w_if_gnt | w_ls_gnt;
    if (w_ls_gnt) begin
      w_addr = bus.ls_addr;
    end else begin
      w_addr = bus.if_addr;
    end
    w_ok = (w_addr >= MEM_BASE) && ((w_addr - MEM_BASE) < MEM_BYTES) && (w_addr[2:0] == 3'd0);
    w_en = w_any_gnt & w_ok;
  end

  always_comb begin
    bus.if_gnt    = w_if_gnt;
    bus.ls_gnt    = w_ls_gnt;
    bus.mem_en    = w_en;
    bus.mem_addr  = w_en ? w_addr : '0;
    bus.mem_we    = (w_en && w_ls_gnt) ? bus.ls_we : 8'h00;
    bus.mem_wdata = (w_en && w_ls_gnt) ? bus.ls_wdata : '0;
  end

  // Writes and errored accesses return zero data; only clean reads forward the sram word.
  always_comb begin
    if (r_rsp_vld && !r_rsp_err && !r_rsp_wr) begin
      w_rsp_data = bus.mem_rdata;
    end else begin
      w_rsp_data = '0;
    end
    bus.if_rvalid = r_rsp_vld & (r_rsp_own == OWN_IF);
    bus.ls_rvalid = r_rsp_vld & (r_rsp_own == OWN_LS);
    bus.if_err    = bus.if_rvalid & r_rsp_err;
    bus.ls_err    = bus.ls_rvalid & r_rsp_err;
    bus.if_rdata  = bus.if_rvalid ? w_rsp_data : '0;
    bus.ls_rdata  = bus.ls_rvalid ? w_rsp_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= OWN_IF;
      r_rsp_vld <= 1'b0;
      r_rsp_own <= OWN_IF;
      r_rsp_err <= 1'b0;
      r_rsp_wr  <= 1'b0;
    end else begin
      r_rsp_vld <= w_any_gnt;
      r_rsp_own <= w_ls_gnt ? OWN_LS : OWN_IF;
      r_rsp_err <= w_any_gnt & ~w_ok;
      r_rsp_wr  <= w_ls_gnt & (bus.ls_we != 8'h00);
      if (w_any_gnt) begin
        r_rr_last <= w_ls_gnt ? OWN_LS : OWN_IF;
      end else begin
        r_rr_last <= r_rr_last;
      end
    end
  end

  sram_arbiter_chk #(.ADDR_W(ADDR_W)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req  (bus.if_req),
    .if_gnt  (w_if_gnt),
    .if_addr (bus.if_addr),
    .ls_req  (bus.ls_req),
    .ls_gnt  (w_ls_gnt),
    .ls_addr (bus.ls_addr)
  );
endmodule

// A waiting requester may withdraw, but must not move its address while still requesting.
module sram_arbiter_chk #(
  parameter int ADDR_W = 64
) (
  input logic              clk,
  input logic              rst_n,
  input logic              if_req,
  input logic              if_gnt,
  input logic [ADDR_W-1:0] if_addr,
  input logic              ls_req,
  input logic              ls_gnt,
  input logic [ADDR_W-1:0] ls_addr
);
  a_if_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (if_req && !if_gnt) |=> (!if_req || (if_addr == $past(if_addr))))
    else $error("if_addr changed while waiting for grant");

  a_ls_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (ls_req && !ls_gnt) |=> (!ls_req || (ls_addr == $past(ls_addr))))
    else $error("ls_addr changed while waiting for grant");
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed vector bench for sram_arbiter with a behavioural registered-read sram model.
module tb_sram_arbiter;
  localparam logic [63:0] W0  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W1  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] W1N = 64'h1111_2222_CCCC_DDDD;
  localparam logic [63:0] W2  = 64'h1122_3344_5566_7788;
  localparam logic [63:0] W3  = 64'hDEAD_BEEF_0000_0003;
  localparam logic [63:0] W4  = 64'hCAFE_F00D_0000_0004;
  localparam logic [63:0] W5  = 64'h5555_AAAA_0000_0005;
  localparam logic [63:0] Z   = 64'h0;
  localparam logic [63:0] A0  = 64'h8000_0000;
  localparam logic [63:0] A1  = 64'h8000_0008;
  localparam logic [63:0] A2  = 64'h8000_0010;
  localparam logic [63:0] WD  = 64'hAAAA_BBBB_CCCC_DDDD;

  typedef struct {
    logic        if_req;  logic [63:0] if_addr;
    logic        ls_req;  logic [7:0]  ls_we;  logic [63:0] ls_addr;  logic [63:0] ls_wdata;
    logic        e_if_gnt; logic e_ls_gnt; logic e_en; logic [7:0] e_we;
    logic        e_if_rv; logic e_if_err; logic [63:0] e_if_rd;
    logic        e_ls_rv; logic e_ls_err; logic [63:0] e_ls_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx = 6'd0;
  logic [63:0] ld_data = 64'h0;
  logic [63:0] sram [0:63];

  vec_t tbl  [20];
  vec_t cont [5];

  sram_arbiter_if bus ();

  sram_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Registered-read sram: read data is the pre-write word, valid the cycle after mem_en.
  always @(posedge clk) begin
    if (ld_en) begin
      sram[ld_idx] <= ld_data;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= sram[bus.mem_addr[8:3]];
      for (int b = 0; b < 8; b++) begin
        if (bus.mem_we[b]) sram[bus.mem_addr[8:3]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.if_req   = v.if_req;
    bus.if_addr  = v.if_addr;
    bus.ls_req   = v.ls_req;
    bus.ls_we    = v.ls_we;
    bus.ls_addr  = v.ls_addr;
    bus.ls_wdata = v.ls_wdata;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    chk({tag, " if_gnt"},    {63'd0, bus.if_gnt},    {63'd0, v.e_if_gnt});
    chk({tag, " ls_gnt"},    {63'd0, bus.ls_gnt},    {63'd0, v.e_ls_gnt});
    chk({tag, " mem_en"},    {63'd0, bus.mem_en},    {63'd0, v.e_en});
    chk({tag, " mem_we"},    {56'd0, bus.mem_we},    {56'd0, v.e_we});
    if (v.e_en) chk({tag, " mem_addr"}, bus.mem_addr, v.e_ls_gnt ? v.ls_addr : v.if_addr);
    chk({tag, " if_rvalid"}, {63'd0, bus.if_rvalid}, {63'd0, v.e_if_rv});
    chk({tag, " if_err"},    {63'd0, bus.if_err},    {63'd0, v.e_if_err});
    chk({tag, " if_rdata"},  bus.if_rdata,           v.e_if_rd);
    chk({tag, " ls_rvalid"}, {63'd0, bus.ls_rvalid}, {63'd0, v.e_ls_rv});
    chk({tag, " ls_err"},    {63'd0, bus.ls_err},    {63'd0, v.e_ls_err});
    chk({tag, " ls_rdata"},  bus.ls_rdata,           v.e_ls_rd);
  endtask

  task automatic idle();
    bus.if_req = 1'b0; bus.if_addr = Z; bus.ls_req = 1'b0;
    bus.ls_we = 8'h00; bus.ls_addr = Z; bus.ls_wdata = Z;
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input int idx, input logic [63:0] d);
    @(posedge clk);
    #1;
    ld_en = 1'b1; ld_idx = idx[5:0]; ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  initial begin
    // in: if_req,if_addr, ls_req,ls_we,ls_addr,ls_wdata | exp: if_gnt,ls_gnt,en,we, if_rv,if_err,if_rd, ls_rv,ls_err,ls_rd
    tbl[0]  = '{1'b1, A2, 1'b0, 8'h00, Z, Z,                           1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z};
    tbl[1]  = '{1'b0, Z,  1'b0, 8'h00, Z, Z,                           1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, W2, 1'b0, 1'b0, Z};
    tbl[2]  = '{1'b0, Z,  1'b1, 8'h0F, A1, WD,                         1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z};
    tbl[3]  = '{1'b0, Z,  1'b1, 8'h00, A1, Z,                          1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, Z,  1'b1, 1'b0, Z};
    tbl[4]  = '{1'b0, Z,  1'b0, 8'h00, Z, Z,                           1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, Z,  1'b1, 1'b0, W1N};
    tbl[5]  = '{1'b0, Z,  1'b1, 8'h00, 64'h7FFF_FFF8, Z,               1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z};
    tbl[6]  = '{1'b0, Z,  1'b1, 8'h00, 64'h8800_0000, Z,               1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, Z,  1'b1, 1'b1, Z};
    tbl[7]  = '{1'b0, Z,  1'b0, 8'h00, Z, Z,                           1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, Z,  1'b1, 1'b1, Z};
    tbl[8]  = '{1'b0, Z,  1'b1, 8'h00, 64'h8000_0004, Z,               1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z};
    tbl[9]  = '{1'b1, 64'h8000_0018, 1'b0, 8'h00, Z, Z,                1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, Z,  1'b1, 1'b1, Z};
    tbl[10] = '{1'b0, Z,  1'b1, 8'h00, A0, Z,                          1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, W3, 1'b0, 1'b0, Z};
    tbl[11] = '{1'b0, Z,  1'b0, 8'h00, Z, Z,                           1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, Z,  1'b1, 1'b0, W0};
    tbl[12] = '{1'b1, A2, 1'b1, 8'h00, 64'h8000_0020, Z,               1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z};
    tbl[13] = '{1'b1, 64'h8000_0028, 1'b1, 8'h00, 64'h8000_0020, Z,    1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, W2, 1'b0, 1'b0, Z};
    tbl[14] = '{1'b1, 64'h8000_0028, 1'b0, 8'h00, Z, Z,                1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, Z,  1'b1, 1'b0, W4};
    tbl[15] = '{1'b0, Z,  1'b0, 8'h00, Z, Z,                           1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, W5, 1'b0, 1'b0, Z};
    tbl[16] = '{1'b1, 64'h0000_1000, 1'b0, 8'h00, Z, Z,                1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z};
    tbl[17] = '{1'b0, Z,  1'b0, 8'h00, Z, Z,                           1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, Z,  1'b0, 1'b0, Z};
    tbl[18] = '{1'b0, Z,  1'b1, 8'hFF, 64'h8800_0000, WD,              1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z};
    tbl[19] = '{1'b0, Z,  1'b0, 8'h00, Z, Z,                           1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, Z,  1'b1, 1'b1, Z};

    // Contention straight after reset: LS wins first, then strict alternation.
    cont[0] = '{1'b1, A2, 1'b1, 8'h00, A1, Z,                          1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z};
    cont[1] = '{1'b1, A2, 1'b1, 8'h00, A1, Z,                          1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, Z,  1'b1, 1'b0, W1N};
    cont[2] = '{1'b1, A2, 1'b1, 8'h00, A1, Z,                          1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, W2, 1'b0, 1'b0, Z};
    cont[3] = '{1'b1, A2, 1'b1, 8'h00, A1, Z,                          1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, Z,  1'b1, 1'b0, W1N};
    cont[4] = '{1'b0, Z,  1'b0, 8'h00, Z, Z,                           1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, W2, 1'b0, 1'b0, Z};

    idle();
    bus.mem_rdata = Z;
    rst_n = 1'b0;
    load(0, W0); load(1, W1); load(2, W2); load(3, W3); load(4, W4); load(5, W5);
    @(negedge clk);
    chk("reset if_rvalid", {63'd0, bus.if_rvalid}, 64'd0);
    chk("reset ls_rvalid", {63'd0, bus.ls_rvalid}, 64'd0);
    chk("reset mem_en",    {63'd0, bus.mem_en},    64'd0);
    chk("reset rdata",     bus.if_rdata | bus.ls_rdata, Z);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    reset_dut();
    for (int i = 0; i < 5; i++) run_vec(cont[i], $sformatf("cont%0d", i));

    // Asynchronous reset with an IF read in flight drops the response.
    @(posedge clk);
    #1;
    bus.if_req = 1'b1; bus.if_addr = A2;
    @(negedge clk);
    chk("inflight if_gnt", {63'd0, bus.if_gnt}, 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst if_rvalid", {63'd0, bus.if_rvalid}, 64'd0);
    chk("rst if_gnt",    {63'd0, bus.if_gnt},    64'd0);
    chk("rst mem_en",    {63'd0, bus.mem_en},    64'd0);
    chk("rst mem_addr",  bus.mem_addr,           Z);
    chk("rst if_rdata",  bus.if_rdata,           Z);
    @(posedge clk);
    #1;
    chk("rst hold mem_en",    {63'd0, bus.mem_en},    64'd0);
    chk("rst hold if_rvalid", {63'd0, bus.if_rvalid}, 64'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("post rst if_rvalid", {63'd0, bus.if_rvalid}, 64'd0);
      chk("post rst ls_rvalid", {63'd0, bus.ls_rvalid}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
